dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares one data-memory port among the N_CORES pipelined cores of the quad-core system.
- Each core's MEM-stage D-port signals (memRead, memWrite, be, addr, wdata) connect to one requester slot.
- A round-robin FSM serializes accesses to a single-port memory with a req/ack handshake.
- Returns read data and a completion pulse per core, and drives per-core stall signals that freeze the requesting pipeline.

Parameters:
- N_CORES, 4, number of requester slots (power of two, ≥2).
- XLEN, 32, data/address width.
- GW, $clog2(N_CORES), grant index width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- req_read  in  N_CORES  per-core load request (core's dmem_memRead).
- req_write  in  N_CORES  per-core store request (core's dmem_memWrite).
- req_be  in  4*N_CORES  per-core byte enables, slot i at [4i+3:4i].
- req_addr  in  XLEN*N_CORES  per-core address, slot i at [XLEN*i +: XLEN].
- req_wdata  in  XLEN*N_CORES  per-core store data.
- resp_valid  out  N_CORES  one-cycle completion pulse per core.
- resp_rdata  out  XLEN  load data, valid only while resp_valid is nonzero.
- stall  out  N_CORES  freezes core i's pipeline while its request is outstanding.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = write, 0 = read.
- mem_be  out  4  byte enables to memory.
- mem_addr  out  XLEN  address to memory.
- mem_wdata  out  XLEN  write data to memory.
- mem_rdata  in  XLEN  read data, valid in the mem_ack cycle.
- mem_ack  in  1  memory completes the transaction this cycle.
- grant_id  out  GW  index of the granted core (debug/perf).
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE, rr_ptr=0, grant_id=0.
  - All mem_* outputs = 0; resp_valid=0; resp_rdata=0; busy=0.
  - Reset mid-transaction aborts it: mem_req drops the cycle after the reset edge, and no resp_valid is issued for the aborted access.
- Request: pend[i] = req_read[i] | req_write[i]. If both are set, the access is a write.
- Stall: stall[i] = pend[i] & ~resp_valid[i], combinational. The core holds its request stable until it sees resp_valid[i].
- Arbitration: round-robin, searching from rr_ptr upward mod N_CORES; the first pend[i] wins. Evaluated only in IDLE.
- States:
  - IDLE: if any pend, latch winner into grant_id, and latch its we/be/addr/wdata into a command register; go to BUSY. Otherwise stay.
  - BUSY: mem_req=1 and mem_* driven from the command register, held constant until mem_ack. On mem_ack, capture resp_rdata = mem_rdata (writes capture 0) and go to RESP.
  - RESP: resp_valid[grant_id]=1 for exactly one cycle; mem_req=0; rr_ptr = grant_id+1 mod N_CORES; go to IDLE.
- Latency:
  - Request first visible in IDLE at cycle T → mem_req at T+1.
  - mem_ack at T+1+k (k≥0) → resp_valid at T+2+k.
  - Minimum 3 cycles per access; throughput 1 access per 3 cycles minimum.
- Request changes after the grant is latched are ignored until RESP. A request withdrawn before grant is never serviced.
- The RESP→IDLE cycle guarantees a completed core has advanced before re-arbitration, so no double service.
- mem_ack outside BUSY is ignored.
- Fairness: with all N cores pending continuously, each is served exactly once per N grants.
- rr_ptr wrap: N_CORES-1 → 0.
- busy = (state != IDLE).

Decomposition:
- Package dmem_arb_pkg holds:
  - state enum {IDLE, BUSY, RESP} (2-bit);
  - packed struct mem_cmd_t {we, be[3:0], addr, wdata}.
- Sub-module rr_pick (combinational): inputs pend[N_CORES] and rr_ptr[GW]; outputs gnt_idx[GW] and any.
- The FSM, command register and response logic live in dmem_arbiter.

Test Plan:
- Single read: core2 req_read, addr=0x100; memory acks 1 cycle after mem_req with 0xDEADBEEF → mem_addr=0x100, mem_we=0 at T+1; resp_valid=4'b0100 and resp_rdata=0xDEADBEEF at T+3; stall[2] high T..T+2.
- Round-robin: all four cores write continuously, mem_ack immediate → grant order 0,1,2,3,0; grant_id sequence matches; each resp_valid one cycle wide.
- Pointer rotation: after core3 served, cores 0 and 2 pending → core0 granted next (wrap); then core2.
- Read+write same core: core1 with both set, wdata=0x12345678, be=4'b0011 → mem_we=1, mem_be=0011, mem_wdata=0x12345678; resp_rdata=0.
- Slow memory: mem_ack delayed 5 cycles, core0 changes addr mid-BUSY → mem_addr stays at original value for all 5 cycles; a spurious mem_ack in IDLE is ignored.
- Reset mid-BUSY: assert rst for 1 cycle while BUSY → next cycle mem_req=0, resp_valid=0, busy=0, rr_ptr=0; next grant goes to lowest pending index.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and the
// latched memory command that is replayed to the memory while BUSY.
package dmem_arb_pkg;

  localparam int ARB_XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                we;
    logic [3:0]          be;
    logic [ARB_XLEN-1:0] addr;
    logic [ARB_XLEN-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending slot at or above rr_ptr,
// wrapping modulo N_CORES.
module rr_pick #(
  parameter int N_CORES = 4,
  parameter int GW      = $clog2(N_CORES)
) (
  input  logic [N_CORES-1:0] pend,
  input  logic [GW-1:0]      rr_ptr,
  output logic [GW-1:0]      gnt_idx,
  output logic               any
);

  logic [GW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest pending slot wins;
  // GW-bit addition wraps naturally because N_CORES is a power of two.
  always_comb begin
    idx     = rr_ptr;
    gnt_idx = rr_ptr;
    any     = 1'b0;
    for (int off = N_CORES - 1; off >= 0; off--) begin
      idx = rr_ptr + GW'(off);
      if (pend[idx]) begin
        gnt_idx = idx;
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory among N_CORES
// pipelined cores; stalls each requester until its one-cycle completion pulse.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int N_CORES = 4,
  parameter int XLEN    = ARB_XLEN,
  parameter int GW      = $clog2(N_CORES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CORES-1:0]      req_read,
  input  logic [N_CORES-1:0]      req_write,
  input  logic [4*N_CORES-1:0]    req_be,
  input  logic [XLEN*N_CORES-1:0] req_addr,
  input  logic [XLEN*N_CORES-1:0] req_wdata,
  output logic [N_CORES-1:0]      resp_valid,
  output logic [XLEN-1:0]         resp_rdata,
  output logic [N_CORES-1:0]      stall,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [3:0]              mem_be,
  output logic [XLEN-1:0]         mem_addr,
  output logic [XLEN-1:0]         mem_wdata,
  input  logic [XLEN-1:0]         mem_rdata,
  input  logic                    mem_ack,
  output logic [GW-1:0]           grant_id,
  output logic                    busy
);

  arb_state_t         state;
  mem_cmd_t           cmd;
  logic [GW-1:0]      rr_ptr;
  logic [GW-1:0]      pick_idx;
  logic               pick_any;
  logic [N_CORES-1:0] pend;

  assign pend = req_read | req_write;

  rr_pick #(
    .N_CORES(N_CORES),
    .GW     (GW)
  ) u_rr_pick (
    .pend   (pend),
    .rr_ptr (rr_ptr),
    .gnt_idx(pick_idx),
    .any    (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant_id   <= '0;
      resp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_id <= pick_idx;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            resp_rdata <= cmd.we ? '0 : mem_rdata;
            state      <= RESP;
          end
        end
        RESP: begin
          rr_ptr <= grant_id + GW'(1);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Command register reloads every IDLE cycle; only the value captured on the
  // IDLE->BUSY edge is ever presented to memory, so later request edits are ignored.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      cmd.we    <= req_write[pick_idx];
      cmd.be    <= req_be[4*pick_idx +: 4];
      cmd.addr  <= req_addr[XLEN*pick_idx +: XLEN];
      cmd.wdata <= req_wdata[XLEN*pick_idx +: XLEN];
    end
  end

  always_comb begin
    mem_req   = (state == BUSY);
    mem_we    = (state == BUSY) ? cmd.we    : 1'b0;
    mem_be    = (state == BUSY) ? cmd.be    : 4'b0;
    mem_addr  = (state == BUSY) ? cmd.addr  : '0;
    mem_wdata = (state == BUSY) ? cmd.wdata : '0;
    busy      = (state != IDLE);
  end

  always_comb begin
    resp_valid = '0;
    if (state == RESP) resp_valid[grant_id] = 1'b1;
  end

  assign stall = pend & ~resp_valid;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: behavioural cores and memory drive the DUT,
// a transaction-level model predicts grants, commands, responses and stalls.
module tb_dmem_arbiter;

  localparam int N    = 4;
  localparam int XLEN = 32;
  localparam int GW   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_read, req_write;
  logic [4*N-1:0]    req_be;
  logic [XLEN*N-1:0] req_addr, req_wdata;
  logic [N-1:0]      resp_valid, stall;
  logic [XLEN-1:0]   resp_rdata;
  logic              mem_req, mem_we, mem_ack, busy;
  logic [3:0]        mem_be;
  logic [XLEN-1:0]   mem_addr, mem_wdata, mem_rdata;
  logic [GW-1:0]     grant_id;

  dmem_arbiter #(.N_CORES(N), .XLEN(XLEN), .GW(GW)) dut (
    .clk(clk), .rst(rst),
    .req_read(req_read), .req_write(req_write), .req_be(req_be),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural cores: each holds at most one request until it is answered.
  bit          c_on[N];
  bit          c_rd[N], c_wr[N];
  logic [3:0]  c_be[N];
  logic [31:0] c_addr[N], c_wdata[N];

  task automatic drive_cores();
    for (int i = 0; i < N; i++) begin
      req_read[i]              = c_on[i] & c_rd[i];
      req_write[i]             = c_on[i] & c_wr[i];
      req_be[4*i +: 4]         = c_be[i];
      req_addr[XLEN*i +: XLEN] = c_addr[i];
      req_wdata[XLEN*i +: XLEN] = c_wdata[i];
    end
  endtask

  typedef enum int {E_IDLE, E_BUSY, E_RESP, E_RESET} exp_t;

  initial begin
    exp_t        ex;
    int          win, ptr, ack_left;
    int          p_req, maxd, p_rst, p_spur, p_wd, ncyc;
    int          gcount[N];
    int          gmin, gmax;
    bit          found;
    logic [N-1:0] pendv, exp_rv;
    logic        we_c;
    logic [3:0]  be_c;
    logic [31:0] addr_c, wdata_c, ack_data, exp_rdata;
    logic [1:0]  rw;

    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    for (int i = 0; i < N; i++) begin
      c_on[i] = 0; c_rd[i] = 0; c_wr[i] = 0;
      c_be[i] = '0; c_addr[i] = '0; c_wdata[i] = '0;
      gcount[i] = 0;
    end
    drive_cores();
    ex = E_RESET; ptr = 0; win = 0; ack_left = 0;
    we_c = 0; be_c = '0; addr_c = '0; wdata_c = '0; ack_data = '0; exp_rdata = '0;

    for (int ph = 0; ph < 3; ph++) begin
      case (ph)
        0:       begin p_req = 100; maxd = 0; p_rst = 0; p_spur = 0;  p_wd = 0;  ncyc = 240; end
        1:       begin p_req = 40;  maxd = 5; p_rst = 3; p_spur = 20; p_wd = 5;  ncyc = 900; end
        default: begin p_req = 15;  maxd = 2; p_rst = 2; p_spur = 30; p_wd = 10; ncyc = 600; end
      endcase

      for (int cyc = 0; cyc < ncyc; cyc++) begin
        @(posedge clk); #1;

        // Observe the state produced by the edge just taken.
        for (int i = 0; i < N; i++) pendv[i] = c_on[i];
        exp_rv = '0;
        if (ex == E_RESP) exp_rv[win] = 1'b1;
        check("stall", stall, pendv & ~exp_rv);

        case (ex)
          E_RESET: begin
            check("rst_busy", busy, 0);
            check("rst_mem_req", mem_req, 0);
            check("rst_resp_valid", resp_valid, 0);
            check("rst_resp_rdata", resp_rdata, 0);
            check("rst_grant_id", grant_id, 0);
            check("rst_mem_we", mem_we, 0);
            check("rst_mem_be", mem_be, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_mem_wdata", mem_wdata, 0);
          end
          E_IDLE: begin
            check("idle_busy", busy, 0);
            check("idle_mem_req", mem_req, 0);
            check("idle_resp_valid", resp_valid, 0);
          end
          E_BUSY: begin
            check("busy_busy", busy, 1);
            check("busy_mem_req", mem_req, 1);
            check("busy_grant_id", grant_id, win);
            check("busy_mem_we", mem_we, we_c);
            check("busy_mem_be", mem_be, be_c);
            check("busy_mem_addr", mem_addr, addr_c);
            check("busy_mem_wdata", mem_wdata, wdata_c);
            check("busy_resp_valid", resp_valid, 0);
          end
          default: begin
            check("resp_valid", resp_valid, exp_rv);
            check("resp_rdata", resp_rdata, exp_rdata);
            check("resp_mem_req", mem_req, 0);
            check("resp_busy", busy, 1);
            c_on[win] = 0;
            ptr = (win + 1) % N;
          end
        endcase

        // Memory side: ack the active access after its delay, or inject noise.
        rst = 1'b0; mem_ack = 1'b0;
        if (ex == E_BUSY && p_rst != 0 && $urandom_range(0, 99) < p_rst) begin
          rst = 1'b1;
        end else if (ex == E_BUSY) begin
          if (ack_left == 0) begin
            mem_ack = 1'b1; mem_rdata = $urandom; ack_data = mem_rdata;
          end else begin
            ack_left--;
            mem_rdata = $urandom;
          end
        end else if ($urandom_range(0, 99) < p_spur) begin
          mem_ack = 1'b1; mem_rdata = $urandom;
        end

        // Core side: new requests, withdrawals, and edits by the granted core.
        for (int i = 0; i < N; i++) begin
          if (c_on[i]) begin
            if (ex == E_BUSY && i == win) begin
              if ($urandom_range(0, 99) < 30) begin
                c_addr[i] = $urandom; c_wdata[i] = $urandom; c_be[i] = 4'($urandom);
              end
            end else if ($urandom_range(0, 99) < p_wd) begin
              c_on[i] = 0;
            end
          end else if ($urandom_range(0, 99) < p_req) begin
            rw = 2'($urandom_range(1, 3));
            c_on[i] = 1; c_rd[i] = rw[0]; c_wr[i] = rw[1];
            c_be[i] = 4'($urandom); c_addr[i] = $urandom; c_wdata[i] = $urandom;
          end
        end
        drive_cores();

        // Predict what the next edge must produce.
        if (rst) begin
          ex = E_RESET; ptr = 0;
        end else begin
          case (ex)
            E_RESP: ex = E_IDLE;
            E_BUSY: begin
              if (mem_ack) begin
                exp_rdata = we_c ? 32'h0 : ack_data;
                ex = E_RESP;
              end
            end
            default: begin
              found = 0;
              for (int k = 0; k < N; k++) begin
                if (!found && c_on[(ptr + k) % N]) begin
                  found = 1; win = (ptr + k) % N;
                end
              end
              if (found) begin
                we_c = c_wr[win]; be_c = c_be[win];
                addr_c = c_addr[win]; wdata_c = c_wdata[win];
                ack_left = $urandom_range(0, maxd);
                if (ph == 0) gcount[win]++;
                ex = E_BUSY;
              end else begin
                ex = E_IDLE;
              end
            end
          endcase
        end
      end

      if (ph == 0) begin
        gmin = gcount[0]; gmax = gcount[0];
        for (int i = 1; i < N; i++) begin
          if (gcount[i] < gmin) gmin = gcount[i];
          if (gcount[i] > gmax) gmax = gcount[i];
        end
        check("fairness_spread", gmax - gmin, 0);
        check("fairness_nonzero", (gmin > 0), 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
